// File: rtl/sensor_avg_bank_if.sv
// Signal bundle between the sensor front ends / drive loop and sensor_avg_bank.
// slave = averaging bank side, master = the block driving samples and strobes.
interface sensor_avg_bank_if #(
  parameter int NCH = 4,
  parameter int DW  = 12
);
  logic [NCH*DW-1:0] smpl;
  logic [NCH-1:0]    mode;
  logic [NCH-1:0]    trig;
  logic [NCH-1:0]    seed;
  logic [3*NCH-1:0]  wt;
  logic [DW-1:0]     target;
  logic [DW-1:0]     batt;
  logic [DW-1:0]     batt_thr;
  logic              not_pedaling;
  logic [NCH*DW-1:0] avg;
  logic [NCH-1:0]    avg_vld;
  logic [NCH-1:0]    ovr;
  logic [DW:0]       error;
  logic              busy;

  modport slave (
    input  smpl, mode, trig, seed, wt, target, batt, batt_thr, not_pedaling,
    output avg, avg_vld, ovr, error, busy
  );

  modport master (
    output smpl, mode, trig, seed, wt, target, batt, batt_thr, not_pedaling,
    input  avg, avg_vld, ovr, error, busy
  );
endinterface

// File: rtl/sensor_avg_bank.sv
// Multi-channel exponential averager with one shared update datapath and a gated error term.
// Optional FAST_SIM_EN: periodic tick on the low 16 timer bits (65536-clock period).
module sensor_avg_bank #(
  parameter int NCH    = 4,
  parameter int DW     = 12,
  parameter int ERR_CH = 0,
  parameter int TMR_W  = 22
) (
  input  logic              clk,
  input  logic              rst,
  sensor_avg_bank_if.slave  bus
);
  localparam int AW = DW + 7;
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {IDLE, UPD} state_t;

  state_t            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [NCH-1:0]    pend_q, pend_d;
  logic [NCH-1:0]    ovr_q, ovr_d;
  logic [NCH-1:0]    vld_q, vld_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [DW:0]       err_q, err_d;
  logic [AW-1:0]     acc_q [NCH];
  logic [AW-1:0]     acc_d [NCH];
  logic [DW-1:0]     avg_q [NCH];
  logic [DW-1:0]     avg_d [NCH];

  logic              tick;
  logic [NCH-1:0]    evt;
  logic              svc_en;
  logic [PW-1:0]     svc_ch;
  logic [PW-1:0]     cand;
  logic              found;
  int                scan_idx;
  logic [2:0]        svc_w;
  logic [AW-1:0]     svc_acc;
  logic [AW-1:0]     upd_acc;
  logic [NCH*DW-1:0] avg_flat;

  function automatic logic [2:0] eff_w(input logic [2:0] w);
    return (w == 3'd0) ? 3'd1 : w;
  endfunction

`ifdef FAST_SIM_EN
  assign tick = &tmr_q[15:0];
`else
  assign tick = &tmr_q;
`endif

  assign evt    = (bus.mode & bus.trig) | (~bus.mode & {NCH{tick}});
  assign svc_en = |pend_q;

  // Round-robin pick: first pending channel at or above the pointer, wrapping.
  always_comb begin
    svc_ch   = '0;
    found    = 1'b0;
    scan_idx = 0;
    cand     = '0;
    for (int k = 0; k < NCH; k++) begin
      scan_idx = int'(ptr_q) + k;
      if (scan_idx >= NCH) scan_idx = scan_idx - NCH;
      cand = PW'(scan_idx);
      if (!found && pend_q[cand]) begin
        found  = 1'b1;
        svc_ch = cand;
      end
    end
  end

  assign svc_w   = eff_w(bus.wt[svc_ch*3 +: 3]);
  assign svc_acc = acc_q[svc_ch];
  assign upd_acc = svc_acc - (svc_acc >> svc_w) + AW'(bus.smpl[svc_ch*DW +: DW]);

  // Pending requests are served from IDLE too, so an uncontended update lands one edge after capture.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (svc_en) state_d = UPD;
      UPD:     if (!svc_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tmr_d  = tmr_q + 1'b1;
    pend_d = pend_q;
    ovr_d  = ovr_q;
    vld_d  = '0;
    ptr_d  = ptr_q;
    acc_d  = acc_q;
    avg_d  = avg_q;

    if (svc_en) begin
      acc_d[svc_ch]  = upd_acc;
      avg_d[svc_ch]  = DW'(upd_acc >> svc_w);
      vld_d[svc_ch]  = 1'b1;
      pend_d[svc_ch] = 1'b0;
      ptr_d          = (int'(svc_ch) == NCH - 1) ? '0 : svc_ch + 1'b1;
    end

    for (int c = 0; c < NCH; c++) begin
      if (bus.seed[c]) begin
        acc_d[c]  = AW'(bus.smpl[c*DW +: DW]) << eff_w(bus.wt[c*3 +: 3]);
        avg_d[c]  = bus.smpl[c*DW +: DW];
        pend_d[c] = 1'b0;
        vld_d[c]  = 1'b1;
      end else if (evt[c]) begin
        // A request already waiting (and not being served now) absorbs this event.
        if (pend_q[c] && !(svc_en && svc_ch == PW'(c))) ovr_d[c] = 1'b1;
        pend_d[c] = 1'b1;
      end
    end
  end

  always_comb begin
    err_d = {1'b0, bus.target} - {1'b0, avg_q[ERR_CH]};
    if (bus.not_pedaling || (bus.batt < bus.batt_thr)) err_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      pend_q  <= '0;
      ovr_q   <= '0;
      vld_q   <= '0;
      ptr_q   <= '0;
      err_q   <= '0;
      for (int c = 0; c < NCH; c++) begin
        acc_q[c] <= '0;
        avg_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      vld_q   <= vld_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
      avg_q   <= avg_d;
    end
  end

  always_comb begin
    avg_flat = '0;
    for (int c = 0; c < NCH; c++) avg_flat[c*DW +: DW] = avg_q[c];
  end

  assign bus.avg     = avg_flat;
  assign bus.avg_vld = vld_q;
  assign bus.ovr     = ovr_q;
  assign bus.error   = err_q;
  assign bus.busy    = (state_q == UPD);
endmodule

// File: tb/tb_sensor_avg_bank.sv
// Directed bench for sensor_avg_bank (NCH=4, DW=12, ERR_CH=0) with hand-computed expectations.
module tb_sensor_avg_bank;
  localparam int NCH = 4;
  localparam int DW  = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  sensor_avg_bank_if #(.NCH(NCH), .DW(DW)) bus ();

  sensor_avg_bank #(.NCH(NCH), .DW(DW), .ERR_CH(0), .TMR_W(22)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.smpl = '0; bus.mode = '0; bus.trig = '0; bus.seed = '0; bus.wt = '0;
    bus.target = '0; bus.batt = '0; bus.batt_thr = '0; bus.not_pedaling = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    bus.target = 12'h555;
    #1;
    n_checks++;
    if ({bus.avg, bus.avg_vld, bus.ovr, bus.busy} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got avg=%h vld=%b ovr=%b busy=%b, want all 0", bus.avg, bus.avg_vld, bus.ovr, bus.busy);
    end
    n_checks++;
    if (bus.error !== 13'h0) begin n_fail++; $display("FAIL reset_error: got %h want 0", bus.error); end
    @(negedge clk);
    rst = 1'b0;
    edge_sample();
    n_checks++;
    if (bus.error !== 13'h555) begin n_fail++; $display("FAIL error_after_reset: got %h want 0555", bus.error); end
  endtask

  task automatic test_seed();
    do_reset();
    bus.smpl[11:0] = 12'h800; bus.wt[2:0] = 3'd2; bus.seed = 4'b0001;
    edge_sample();
    n_checks++;
    if (bus.avg[11:0] !== 12'h800 || bus.avg_vld !== 4'b0001) begin
      n_fail++; $display("FAIL seed_ch0: got avg=%h vld=%b want 800 0001", bus.avg[11:0], bus.avg_vld);
    end
    // acc is 0x2000 after the seed: one update with smpl 0x400 gives 0x1C00 -> avg 0x700
    @(negedge clk);
    bus.seed = '0; bus.smpl[11:0] = 12'h400; bus.mode[0] = 1'b1; bus.trig[0] = 1'b1;
    edge_sample();
    @(negedge clk);
    bus.trig = '0;
    edge_sample();
    n_checks++;
    if (bus.avg[11:0] !== 12'h700 || bus.avg_vld !== 4'b0001) begin
      n_fail++; $display("FAIL seed_then_update: got avg=%h vld=%b want 700 0001", bus.avg[11:0], bus.avg_vld);
    end
    // seed and trig together on ch1: the trig must be discarded
    @(negedge clk);
    bus.mode[1] = 1'b1; bus.wt[5:3] = 3'd1; bus.smpl[23:12] = 12'h0AB;
    bus.seed[1] = 1'b1; bus.trig[1] = 1'b1;
    edge_sample();
    n_checks++;
    if (bus.avg[23:12] !== 12'h0AB || bus.avg_vld !== 4'b0010) begin
      n_fail++; $display("FAIL seed_ch1: got avg=%h vld=%b want 0ab 0010", bus.avg[23:12], bus.avg_vld);
    end
    @(negedge clk);
    bus.seed = '0; bus.trig = '0;
    for (int i = 0; i < 2; i++) begin
      edge_sample();
      n_checks++;
      if (bus.avg_vld !== 4'b0000 || bus.busy !== 1'b0 || bus.avg[23:12] !== 12'h0AB) begin
        n_fail++; $display("FAIL seed_discards_trig[%0d]: got vld=%b busy=%b avg=%h want 0000 0 0ab", i, bus.avg_vld, bus.busy, bus.avg[23:12]);
      end
    end
  endtask

  task automatic test_triggered();
    logic [11:0] exp_avg [3];
    exp_avg[0] = 12'h080; exp_avg[1] = 12'h0C0; exp_avg[2] = 12'h0E0;
    do_reset();
    bus.mode[1] = 1'b1; bus.wt[5:3] = 3'd1; bus.smpl[23:12] = 12'h100;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      if (t == 2) bus.wt[5:3] = 3'd0;
      bus.trig[1] = 1'b1;
      edge_sample();
      n_checks++;
      if (bus.avg_vld !== 4'b0000) begin n_fail++; $display("FAIL trig_early_vld[%0d]: got %b want 0000", t, bus.avg_vld); end
      @(negedge clk);
      bus.trig = '0;
      edge_sample();
      n_checks++;
      if (bus.avg[23:12] !== exp_avg[t] || bus.avg_vld !== 4'b0010) begin
        n_fail++; $display("FAIL trig_update[%0d]: got avg=%h vld=%b want %h 0010", t, bus.avg[23:12], bus.avg_vld, exp_avg[t]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_vld [6];
    logic       exp_busy [6];
    exp_vld[0] = 4'b0000; exp_busy[0] = 1'b0;
    exp_vld[1] = 4'b0001; exp_busy[1] = 1'b1;
    exp_vld[2] = 4'b0010; exp_busy[2] = 1'b1;
    exp_vld[3] = 4'b0100; exp_busy[3] = 1'b1;
    exp_vld[4] = 4'b1000; exp_busy[4] = 1'b1;
    exp_vld[5] = 4'b0000; exp_busy[5] = 1'b0;
    do_reset();
    bus.mode = 4'b1111; bus.wt = {3'd1, 3'd1, 3'd1, 3'd1};
    bus.smpl = {12'h400, 12'h300, 12'h200, 12'h100};
    bus.trig = 4'b1111;
    edge_sample();
    @(negedge clk);
    bus.trig = '0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) edge_sample();
      else #1;
      n_checks++;
      if (bus.avg_vld !== exp_vld[i] || bus.busy !== exp_busy[i]) begin
        n_fail++; $display("FAIL b2b_cycle[%0d]: got vld=%b busy=%b want %b %b", i, bus.avg_vld, bus.busy, exp_vld[i], exp_busy[i]);
      end
    end
    n_checks++;
    if (bus.avg !== {12'h200, 12'h180, 12'h100, 12'h080} || bus.ovr !== 4'b0000) begin
      n_fail++; $display("FAIL b2b_values: got avg=%h ovr=%b want 200180100080 0000", bus.avg, bus.ovr);
    end
    // reset in the middle of a scan
    @(negedge clk);
    bus.trig = 4'b1111;
    edge_sample();
    @(negedge clk);
    bus.trig = '0;
    edge_sample();
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || {bus.avg, bus.avg_vld, bus.ovr, bus.error} !== '0) begin
      n_fail++; $display("FAIL midscan_reset: got busy=%b avg=%h vld=%b err=%h want all 0", bus.busy, bus.avg, bus.avg_vld, bus.error);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      edge_sample();
      n_checks++;
      if (bus.avg_vld !== 4'b0000 || bus.busy !== 1'b0) begin
        n_fail++; $display("FAIL pending_lost[%0d]: got vld=%b busy=%b want 0000 0", i, bus.avg_vld, bus.busy);
      end
    end
  endtask

  task automatic test_overrun();
    int n_upd;
    n_upd = 0;
    do_reset();
    bus.mode = 4'b1111; bus.wt = {3'd1, 3'd1, 3'd1, 3'd1};
    bus.smpl[35:24] = 12'h200;
    bus.trig = 4'b0111;
    edge_sample();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.trig = (i < 2) ? 4'b0100 : 4'b0000;
      edge_sample();
      if (bus.avg_vld[2]) n_upd++;
    end
    n_checks++;
    if (n_upd !== 1) begin n_fail++; $display("FAIL ovr_update_count: got %0d want 1", n_upd); end
    n_checks++;
    if (bus.ovr !== 4'b0100 || bus.avg[35:24] !== 12'h100) begin
      n_fail++; $display("FAIL ovr_flags: got ovr=%b avg2=%h want 0100 100", bus.ovr, bus.avg[35:24]);
    end
  endtask

  task automatic test_error();
    do_reset();
    bus.wt[2:0] = 3'd2; bus.smpl[11:0] = 12'h300; bus.seed = 4'b0001;
    edge_sample();
    @(negedge clk);
    bus.seed = '0; bus.target = 12'h500; bus.batt = 12'h800; bus.batt_thr = 12'h400;
    edge_sample();
    n_checks++;
    if (bus.error !== 13'h0200) begin n_fail++; $display("FAIL error_pos: got %h want 0200", bus.error); end
    @(negedge clk);
    bus.batt = 12'h100;
    edge_sample();
    n_checks++;
    if (bus.error !== 13'h0000) begin n_fail++; $display("FAIL error_low_batt: got %h want 0000", bus.error); end
    @(negedge clk);
    bus.batt = 12'h400;
    edge_sample();
    n_checks++;
    if (bus.error !== 13'h0200) begin n_fail++; $display("FAIL error_batt_eq_thr: got %h want 0200", bus.error); end
    @(negedge clk);
    bus.not_pedaling = 1'b1;
    edge_sample();
    n_checks++;
    if (bus.error !== 13'h0000) begin n_fail++; $display("FAIL error_not_pedaling: got %h want 0000", bus.error); end
    @(negedge clk);
    bus.not_pedaling = 1'b0; bus.target = 12'h100;
    edge_sample();
    n_checks++;
    if (bus.error !== 13'h1E00) begin n_fail++; $display("FAIL error_neg: got %h want 1e00", bus.error); end
  endtask

  task automatic test_periodic();
    int  n;
    logic hit;
    n = 0; hit = 1'b0;
    do_reset();
    bus.mode = 4'b0111; bus.wt[11:9] = 3'd1; bus.smpl[47:36] = 12'h100;
`ifdef FAST_SIM_EN
    while (n < 70000 && !hit) begin
      edge_sample();
      n++;
      if (bus.avg_vld[3]) hit = 1'b1;
    end
    n_checks++;
    if (!hit || n != 65537 || bus.avg[47:36] !== 12'h080) begin
      n_fail++; $display("FAIL periodic_tick: got hit=%b edges=%0d avg3=%h want 1 65537 080", hit, n, bus.avg[47:36]);
    end
`else
    for (int i = 0; i < 300; i++) begin
      edge_sample();
      if (bus.avg_vld != 4'b0000) n++;
    end
    n_checks++;
    if (n != 0) begin n_fail++; $display("FAIL periodic_no_early_tick: got %0d pulses want 0", n); end
`endif
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_seed();
    test_triggered();
    test_back_to_back();
    test_overrun();
    test_error();
    test_periodic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
